if_fetch_queue: RTL

// - Instruction-fetch stage directly downstream of the PC register: accepts PC values, issues

---
 rtl/if_fetch_queue.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/if_fetch_queue.sv
// Instruction-fetch queue: issues imem reads for accepted PCs and returns {pc, instr} in order.
// Optional misaligned-fetch fault entries are enabled with `define FETCH_MISALIGN_CHK_EN.
module if_fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pc_valid,
    input  logic [XLEN-1:0] pc,
    output logic            pc_ready,
    input  logic            redirect,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr,
    output logic            out_misaligned,
    input  logic            out_ready
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = IW + 1;
    localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);

    logic [XLEN-1:0] pc_q    [DEPTH];
    logic [XLEN-1:0] instr_q [DEPTH];
    logic [DEPTH-1:0] done_q;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] fill_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] discard_cnt;

    logic [PW-1:0] count_c;
    logic [PW-1:0] outstanding_c;
    logic          full_c;
    logic          misal_pc_c;
    logic          issue_ok_c;
    logic          misal_acc_c;
    logic          alloc_c;
    logic          fill_c;
    logic          drop_c;
    logic          pop_c;

    logic [IW-1:0] wr_idx;
    logic [IW-1:0] fill_idx;
    logic [IW-1:0] rd_idx;

    assign wr_idx   = wr_ptr[IW-1:0];
    assign fill_idx = fill_ptr[IW-1:0];
    assign rd_idx   = rd_ptr[IW-1:0];

    // Issue, fill and pop decisions for the current cycle.
    always_comb begin
        count_c       = wr_ptr - rd_ptr;
        outstanding_c = wr_ptr - fill_ptr;
        full_c        = (count_c == PW'(DEPTH));
`ifdef FETCH_MISALIGN_CHK_EN
        misal_pc_c    = (pc[1:0] != 2'b00);
`else
        misal_pc_c    = 1'b0;
`endif
        issue_ok_c     = pc_valid && !full_c && !redirect;
        imem_req_valid = issue_ok_c && !misal_pc_c;
        imem_req_addr  = pc;
        // A faulting fetch may only enter once every earlier request has returned.
        misal_acc_c    = issue_ok_c && misal_pc_c && (wr_ptr == fill_ptr);
        pc_ready       = (imem_req_valid && imem_req_ready) || misal_acc_c;
        alloc_c        = pc_ready;
        fill_c         = imem_rsp_valid && (discard_cnt == '0) && !redirect;
        drop_c         = imem_rsp_valid && (discard_cnt != '0) && !redirect;
        out_valid      = done_q[rd_idx] && (count_c != '0) && !redirect;
        pop_c          = out_valid && out_ready;
    end

    assign out_pc    = pc_q[rd_idx];
    assign out_instr = instr_q[rd_idx];

    // Pointer and discard bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            fill_ptr    <= '0;
            rd_ptr      <= '0;
            discard_cnt <= '0;
        end else if (redirect) begin
            wr_ptr      <= '0;
            fill_ptr    <= '0;
            rd_ptr      <= '0;
            // Every outstanding request still returns; a response arriving now is one of them.
            discard_cnt <= discard_cnt + outstanding_c - PW'(imem_rsp_valid);
        end else begin
            if (alloc_c) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (misal_acc_c || fill_c) begin
                fill_ptr <= fill_ptr + PW'(1);
            end
            if (drop_c) begin
                discard_cnt <= discard_cnt - PW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Entry storage: allocation writes pc, response fills instr and done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
        end else if (redirect) begin
            done_q <= '0;
        end else begin
            if (alloc_c) begin
                pc_q[wr_idx]   <= pc;
                done_q[wr_idx] <= misal_acc_c;
                if (misal_acc_c) begin
                    instr_q[wr_idx] <= NOP_INSTR;
                end
            end
            if (fill_c && !misal_acc_c) begin
                instr_q[fill_idx] <= imem_rsp_data;
                done_q[fill_idx]  <= 1'b1;
            end
        end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    logic [DEPTH-1:0] misal_q;

    // Fault flag travels with its entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misal_q <= '0;
        end else if (redirect) begin
            misal_q <= '0;
        end else if (alloc_c) begin
            misal_q[wr_idx] <= misal_acc_c;
        end
    end

    assign out_misaligned = misal_q[rd_idx];
`else
    assign out_misaligned = 1'b0;
`endif

endmodule
